// File: rtl/daq_event_framer.sv
// Frames ASoC sample events into 32-bit DAQ words: header, packed sample pairs, optional pad, trailer.
// Optional feature: define DAQ_FRAMER_CHECKSUM_EN to append an XOR checksum word after each trailer.
module daq_event_framer #(
  parameter int SAMPLE_W    = 12,
  parameter int MAX_SAMPLES = 1024
) (
  input  logic                clk_sys,
  input  logic                rst_sys_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic [5:0]          s_chan,
  input  logic                s_first,
  input  logic                s_last,
  output logic [31:0]         daq_data_out,
  output logic                daq_valid,
  input  logic                daq_ready
);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_TRAIL, ST_CHK} state_t;

  localparam logic [15:0] MAX_CNT = 16'(MAX_SAMPLES);

  state_t      state_q, state_d;
  logic        run_q, run_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic [15:0] evt_cnt_q, evt_cnt_d;
  logic [15:0] sample_cnt_q, sample_cnt_d;
  logic [2:0]  flags_q, flags_d;
  logic        half_q, half_d;
  logic [15:0] lane_lo_q, lane_lo_d;
  logic        pad_pend_q, pad_pend_d;
`ifdef DAQ_FRAMER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;
`endif

  logic        slot_free_s;
  logic        s_ready_s;
  logic        start_s;
  logic        proc_s;
  logic [15:0] lane_s;
  logic [15:0] cnt_c;
  logic [2:0]  flags_c;
  logic        half_c;

  // Next-state, output-slot and sample-packing logic.
  always_comb begin
    state_d      = state_q;
    run_d        = 1'b1;
    valid_d      = valid_q && !daq_ready;
    data_d       = data_q;
    evt_cnt_d    = evt_cnt_q;
    lane_lo_d    = lane_lo_q;
    pad_pend_d   = pad_pend_q;
`ifdef DAQ_FRAMER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    slot_free_s  = !valid_q || daq_ready;
    s_ready_s    = 1'b0;
    start_s      = 1'b0;
    proc_s       = 1'b0;
    lane_s       = 16'(s_data);
    cnt_c        = sample_cnt_q;
    flags_c      = flags_q;
    half_c       = half_q;

    case (state_q)
      ST_IDLE: begin
        s_ready_s = run_q && slot_free_s;
        start_s   = s_valid && s_ready_s && s_first;
      end
      ST_DATA: begin
        s_ready_s = run_q && slot_free_s;
        proc_s    = s_valid && s_ready_s;
      end
      ST_TRAIL: begin
        if (slot_free_s && pad_pend_q) begin
          data_d     = {16'h8000, lane_lo_q};
          valid_d    = 1'b1;
          pad_pend_d = 1'b0;
`ifdef DAQ_FRAMER_CHECKSUM_EN
          csum_d     = csum_q ^ {16'h8000, lane_lo_q};
`endif
        end else if (slot_free_s) begin
          data_d    = {8'h5A, 5'b00000, flags_q, sample_cnt_q};
          valid_d   = 1'b1;
          evt_cnt_d = evt_cnt_q + 16'd1;
`ifdef DAQ_FRAMER_CHECKSUM_EN
          state_d   = ST_CHK;
`else
          state_d   = ST_IDLE;
`endif
        end else begin
          state_d = ST_TRAIL;
        end
      end
`ifdef DAQ_FRAMER_CHECKSUM_EN
      ST_CHK: begin
        if (slot_free_s) begin
          data_d  = csum_q;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CHK;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // The first sample loads the header, then falls through to normal sample handling.
    if (start_s) begin
      data_d  = {8'hA5, 2'b00, s_chan, evt_cnt_q};
      valid_d = 1'b1;
      cnt_c   = 16'd0;
      flags_c = 3'b000;
      half_c  = 1'b0;
`ifdef DAQ_FRAMER_CHECKSUM_EN
      csum_d  = 32'h0000_0000;
`endif
    end else begin
      cnt_c   = sample_cnt_q;
    end

    if (start_s || proc_s) begin
      if (proc_s && s_first) begin
        flags_c[2] = 1'b1;
      end else begin
        flags_c[2] = flags_c[2];
      end
      if (cnt_c < MAX_CNT) begin
        cnt_c = cnt_c + 16'd1;
        if (!half_c) begin
          lane_lo_d = lane_s;
          half_c    = 1'b1;
        end else begin
          data_d  = {lane_s, lane_lo_q};
          valid_d = 1'b1;
          half_c  = 1'b0;
`ifdef DAQ_FRAMER_CHECKSUM_EN
          csum_d  = csum_d ^ {lane_s, lane_lo_q};
`endif
        end
      end else begin
        flags_c[0] = 1'b1;
      end
      // A lone pending low lane is padded; the header may still own the slot, so defer then.
      if (s_last) begin
        if (half_c && start_s) begin
          pad_pend_d = 1'b1;
          flags_c[1] = 1'b1;
        end else if (half_c) begin
          data_d     = {16'h8000, lane_lo_d};
          valid_d    = 1'b1;
          flags_c[1] = 1'b1;
`ifdef DAQ_FRAMER_CHECKSUM_EN
          csum_d     = csum_d ^ {16'h8000, lane_lo_d};
`endif
        end else begin
          pad_pend_d = 1'b0;
        end
        half_c  = 1'b0;
        state_d = ST_TRAIL;
      end else begin
        state_d = ST_DATA;
      end
    end else begin
      pad_pend_d = pad_pend_d;
    end

    sample_cnt_d = cnt_c;
    flags_d      = flags_c;
    half_d       = half_c;
  end

  // State and datapath registers.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q      <= ST_IDLE;
      run_q        <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= 32'h0000_0000;
      evt_cnt_q    <= 16'd0;
      sample_cnt_q <= 16'd0;
      flags_q      <= 3'b000;
      half_q       <= 1'b0;
      lane_lo_q    <= 16'd0;
      pad_pend_q   <= 1'b0;
`ifdef DAQ_FRAMER_CHECKSUM_EN
      csum_q       <= 32'h0000_0000;
`endif
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      evt_cnt_q    <= evt_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      flags_q      <= flags_d;
      half_q       <= half_d;
      lane_lo_q    <= lane_lo_d;
      pad_pend_q   <= pad_pend_d;
`ifdef DAQ_FRAMER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign s_ready      = s_ready_s;
  assign daq_data_out = data_q;
  assign daq_valid    = valid_q;

endmodule

// File: tb/tb_daq_event_framer.sv
// Directed scoreboard bench for daq_event_framer (MAX_SAMPLES=4 so truncation is reachable).
module tb_daq_event_framer;

  logic        clk_sys = 1'b0;
  logic        rst_sys_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [11:0] s_data = 12'h000;
  logic [5:0]  s_chan = 6'd0;
  logic        s_first = 1'b0;
  logic        s_last = 1'b0;
  logic [31:0] daq_data_out;
  logic        daq_valid;
  logic        daq_ready = 1'b1;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;
  logic        ok;

  daq_event_framer #(.SAMPLE_W(12), .MAX_SAMPLES(4)) dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_chan(s_chan),
    .s_first(s_first), .s_last(s_last),
    .daq_data_out(daq_data_out), .daq_valid(daq_valid), .daq_ready(daq_ready)
  );

  always #5 clk_sys = ~clk_sys;

  // Output monitor: every handshake pops one expected word.
  always @(negedge clk_sys) begin
    if (rst_sys_n && daq_valid && daq_ready) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_word observed=%08h expected=none", daq_data_out);
      end
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        n_checks++;
        assert (daq_data_out === exp_w) else begin
          n_fail++;
          $error("FAIL word observed=%08h expected=%08h", daq_data_out, exp_w);
        end
      end
    end
  end

  task automatic push(input logic [31:0] w);
    exp_q.push_back(w);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [11:0] d, input logic [5:0] ch, input logic f, input logic l);
    s_valid = 1'b1; s_data = d; s_chan = ch; s_first = f; s_last = l;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk_sys);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("send_accept", {31'd0, ok}, 32'd1);
    @(posedge clk_sys); #1;
    s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      @(posedge clk_sys);
      if (exp_q.size() == 0) break;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk_sys); #1;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_valid", {31'd0, daq_valid}, 32'd0);
    check("rst_data", daq_data_out, 32'h0000_0000);
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    @(posedge clk_sys); #1; rst_sys_n = 1'b1;
    @(posedge clk_sys); #1;

    // Even event, chan 3
    push(32'hA503_0000); push(32'h0002_0001); push(32'h0004_0003); push(32'h5A00_0004);
`ifdef DAQ_FRAMER_CHECKSUM_EN
    push(32'h0002_0001 ^ 32'h0004_0003);
`endif
    send(12'h001, 6'd3, 1'b1, 1'b0);
    send(12'h002, 6'd3, 1'b0, 1'b0);
    send(12'h003, 6'd3, 1'b0, 1'b0);
    send(12'h004, 6'd3, 1'b0, 1'b1);
    drain();

    // Odd event, chan 0, second frame
    push(32'hA500_0001); push(32'h000B_000A); push(32'h8000_000C); push(32'h5A02_0003);
`ifdef DAQ_FRAMER_CHECKSUM_EN
    push(32'h000B_000A ^ 32'h8000_000C);
`endif
    send(12'h00A, 6'd0, 1'b1, 1'b0);
    send(12'h00B, 6'd0, 1'b0, 1'b0);
    send(12'h00C, 6'd0, 1'b0, 1'b1);
    drain();

    // Backpressure mid-frame with a sample waiting
    push(32'hA503_0002); push(32'h0002_0001); push(32'h0004_0003); push(32'h5A00_0004);
`ifdef DAQ_FRAMER_CHECKSUM_EN
    push(32'h0002_0001 ^ 32'h0004_0003);
`endif
    send(12'h001, 6'd3, 1'b1, 1'b0);
    send(12'h002, 6'd3, 1'b0, 1'b0);
    daq_ready = 1'b0; s_valid = 1'b1; s_data = 12'h003;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_sys);
      check("bp_data", daq_data_out, 32'h0002_0001);
      check("bp_valid", {31'd0, daq_valid}, 32'd1);
      check("bp_s_ready", {31'd0, s_ready}, 32'd0);
    end
    @(posedge clk_sys); #1; daq_ready = 1'b1;
    send(12'h003, 6'd3, 1'b0, 1'b0);
    send(12'h004, 6'd3, 1'b0, 1'b1);
    drain();

    // Truncation: 6 samples with MAX_SAMPLES=4
    push(32'hA504_0003); push(32'h0002_0001); push(32'h0004_0003); push(32'h5A01_0004);
`ifdef DAQ_FRAMER_CHECKSUM_EN
    push(32'h0002_0001 ^ 32'h0004_0003);
`endif
    send(12'h001, 6'd4, 1'b1, 1'b0);
    for (int i = 2; i <= 5; i++) send(12'(i), 6'd4, 1'b0, 1'b0);
    send(12'h006, 6'd4, 1'b0, 1'b1);
    drain();

    // Stray first marker on sample 2
    push(32'hA505_0004); push(32'h0002_0001); push(32'h0004_0003); push(32'h5A04_0004);
`ifdef DAQ_FRAMER_CHECKSUM_EN
    push(32'h0002_0001 ^ 32'h0004_0003);
`endif
    send(12'h001, 6'd5, 1'b1, 1'b0);
    send(12'h002, 6'd5, 1'b1, 1'b0);
    send(12'h003, 6'd5, 1'b0, 1'b0);
    send(12'h004, 6'd5, 1'b0, 1'b1);
    drain();

    // Reset mid-frame abandons the frame
    push(32'hA502_0005); push(32'h0002_0001);
    send(12'h001, 6'd2, 1'b1, 1'b0);
    send(12'h002, 6'd2, 1'b0, 1'b0);
    check("pre_rst_pending", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    rst_sys_n = 1'b0; #1;
    check("midrst_valid", {31'd0, daq_valid}, 32'd0);
    check("midrst_s_ready", {31'd0, s_ready}, 32'd0);
    check("midrst_data", daq_data_out, 32'h0000_0000);
    repeat (2) @(posedge clk_sys); #1;
    rst_sys_n = 1'b1;
    repeat (2) @(posedge clk_sys); #1;

    push(32'hA501_0000); push(32'h0008_0007); push(32'h5A00_0002);
`ifdef DAQ_FRAMER_CHECKSUM_EN
    push(32'h0008_0007);
`endif
    send(12'h007, 6'd1, 1'b1, 1'b0);
    send(12'h008, 6'd1, 1'b0, 1'b1);
    drain();

    repeat (3) @(posedge clk_sys);
    check("idle_valid", {31'd0, daq_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
